// File: rtl/core_mem_arbiter.sv
// Single-port SRAM arbiter between a host port and a corelet port.
// Ownership changes go through a READ_LAT-cycle drain so in-flight reads land on the port that issued them.
module core_mem_arbiter #(
    parameter int DW       = 32,
    parameter int AW       = 7,
    parameter int READ_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             host_sel,
    input  logic             host_cen,
    input  logic             host_wen,
    input  logic [AW-1:0]    host_addr,
    input  logic [DW-1:0]    host_d,
    output logic [DW-1:0]    host_q,
    output logic             host_qvalid,
    input  logic             core_cen,
    input  logic             core_wen,
    input  logic [AW-1:0]    core_addr,
    input  logic [DW-1:0]    core_d,
    output logic [DW-1:0]    core_q,
    output logic             core_qvalid,
    output logic             mem_cen,
    output logic             mem_wen,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_d,
    input  logic [DW-1:0]    mem_q,
    output logic [1:0]       owner,
    output logic             core_grant,
    output logic             host_err,
    output logic [CNT_W-1:0] access_cnt
);

    // Handshake: cen/wen are active-low single-cycle strobes with no stall; every
    // strobe from the owning port is accepted in the cycle it is driven. qvalid is a
    // one-cycle pulse with no ready; the receiving port must take q in that cycle.

    typedef enum logic [1:0] {
        S_HOST          = 2'b00,
        S_DRAIN_TO_CORE = 2'b01,
        S_CORE          = 2'b10,
        S_DRAIN_TO_HOST = 2'b11
    } state_t;

    localparam logic [2:0]       DRAIN_LAST = 3'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t              state, state_nxt;
    logic [2:0]          drain_cnt, drain_cnt_nxt;
    logic                enter_window;
    logic                acc_host, acc_core, acc, rd_issue;
    logic [READ_LAT-1:0] pipe_vld, pipe_tag;
    logic                out_vld, out_tag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_HOST;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = '0;
        enter_window  = 1'b0;
        case (state)
            S_HOST: if (!host_sel) state_nxt = S_DRAIN_TO_CORE;
            S_CORE: if (host_sel) state_nxt = S_DRAIN_TO_HOST;
            S_DRAIN_TO_CORE: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt    = S_CORE;
                    enter_window = 1'b1;
                end else begin
                    drain_cnt_nxt = drain_cnt + 3'd1;
                end
            end
            S_DRAIN_TO_HOST: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt    = S_HOST;
                    enter_window = 1'b1;
                end else begin
                    drain_cnt_nxt = drain_cnt + 3'd1;
                end
            end
            default: state_nxt = S_HOST;
        endcase
    end

    // SRAM strobes are forced idle while reset is held, even though the state reads HOST.
    always_comb begin
        mem_cen  = 1'b1;
        mem_wen  = 1'b1;
        mem_addr = '0;
        mem_d    = '0;
        if (reset) begin
            case (state)
                S_HOST: begin
                    mem_cen  = host_cen;
                    mem_wen  = host_wen;
                    mem_addr = host_addr;
                    mem_d    = host_d;
                end
                S_CORE: begin
                    mem_cen  = core_cen;
                    mem_wen  = core_wen;
                    mem_addr = core_addr;
                    mem_d    = core_d;
                end
                default: ;
            endcase
        end
    end

    assign acc_host = (state == S_HOST) && !host_cen;
    assign acc_core = (state == S_CORE) && !core_cen;
    assign acc      = acc_host || acc_core;
    assign rd_issue = (acc_host && host_wen) || (acc_core && core_wen);

    // Tag bit: 1 = read was issued by the corelet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_vld <= '0;
            pipe_tag <= '0;
        end else begin
            pipe_vld[0] <= rd_issue;
            pipe_tag[0] <= acc_core;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    assign out_vld     = pipe_vld[READ_LAT-1];
    assign out_tag     = pipe_tag[READ_LAT-1];
    assign host_qvalid = out_vld && !out_tag;
    assign core_qvalid = out_vld && out_tag;
    assign host_q      = host_qvalid ? mem_q : '0;
    assign core_q      = core_qvalid ? mem_q : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_err   <= 1'b0;
            access_cnt <= '0;
        end else begin
            host_err <= host_err || (!host_cen && state != S_HOST);
            if (enter_window) begin
                access_cnt <= '0;
            end else if (acc && access_cnt != CNT_MAX) begin
                access_cnt <= access_cnt + CNT_W'(1);
            end
        end
    end

    assign owner      = state;
    assign core_grant = (state == S_CORE);

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter with a behavioural SRAM and a read-return scoreboard.
module tb_core_mem_arbiter;

  localparam int DW       = 32;
  localparam int AW       = 7;
  localparam int READ_LAT = 2;
  localparam int CNT_W    = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             host_sel, host_cen, host_wen;
  logic [AW-1:0]    host_addr;
  logic [DW-1:0]    host_d, host_q;
  logic             host_qvalid;
  logic             core_cen, core_wen;
  logic [AW-1:0]    core_addr;
  logic [DW-1:0]    core_d, core_q;
  logic             core_qvalid;
  logic             mem_cen, mem_wen;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_d, mem_q;
  logic [1:0]       owner;
  logic             core_grant, host_err;
  logic [CNT_W-1:0] access_cnt;

  int checks = 0;
  int failures = 0;
  logic [DW:0] exp_q[$];

  core_mem_arbiter #(.DW(DW), .AW(AW), .READ_LAT(READ_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .host_sel(host_sel),
    .host_cen(host_cen), .host_wen(host_wen), .host_addr(host_addr), .host_d(host_d),
    .host_q(host_q), .host_qvalid(host_qvalid),
    .core_cen(core_cen), .core_wen(core_wen), .core_addr(core_addr), .core_d(core_d),
    .core_q(core_q), .core_qvalid(core_qvalid),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_d(mem_d), .mem_q(mem_q),
    .owner(owner), .core_grant(core_grant), .host_err(host_err), .access_cnt(access_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // SRAM model: write on strobe, read data READ_LAT cycles after the read strobe
  logic [DW-1:0] sram [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [READ_LAT];
  always @(posedge clk) begin
    if (!mem_cen && !mem_wen) sram[mem_addr] <= mem_d;
    rd_pipe[0] <= (!mem_cen && mem_wen) ? sram[mem_addr] : '0;
    for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_q = rd_pipe[READ_LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: bit DW of an entry is the port (1 = core)
  always @(negedge clk) begin : mon
    logic [DW:0] e;
    if (host_qvalid || core_qvalid) begin
      check("qvalid_onehot", 64'(host_qvalid & core_qvalid), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_qvalid", {62'd0, host_qvalid, core_qvalid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        if (e[DW]) begin
          check("sb_core_qvalid", 64'(core_qvalid), 64'd1);
          check("sb_core_q", 64'(core_q), 64'(e[DW-1:0]));
          check("sb_host_q_idle", 64'(host_q), 64'd0);
        end else begin
          check("sb_host_qvalid", 64'(host_qvalid), 64'd1);
          check("sb_host_q", 64'(host_q), 64'(e[DW-1:0]));
          check("sb_core_q_idle", 64'(core_q), 64'd0);
        end
      end
    end else begin
      check("sb_host_q_zero", 64'(host_q), 64'd0);
      check("sb_core_q_zero", 64'(core_q), 64'd0);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    host_cen = 1'b1; host_wen = 1'b1; host_addr = '0; host_d = '0;
    core_cen = 1'b1; core_wen = 1'b1; core_addr = '0; core_d = '0;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_owner"}, 64'(owner), 64'd0);
    check({tag, "_core_grant"}, 64'(core_grant), 64'd0);
    check({tag, "_host_err"}, 64'(host_err), 64'd0);
    check({tag, "_access_cnt"}, 64'(access_cnt), 64'd0);
    check({tag, "_host_qvalid"}, 64'(host_qvalid), 64'd0);
    check({tag, "_core_qvalid"}, 64'(core_qvalid), 64'd0);
    check({tag, "_host_q"}, 64'(host_q), 64'd0);
    check({tag, "_core_q"}, 64'(core_q), 64'd0);
    check({tag, "_mem_cen"}, 64'(mem_cen), 64'd1);
    check({tag, "_mem_wen"}, 64'(mem_wen), 64'd1);
  endtask

  initial begin
    host_sel = 1'b1;
    idle_inputs();
    // host strobes active during reset must not reach the SRAM
    host_cen = 1'b0; host_wen = 1'b0; host_addr = 7'h55; host_d = 32'h1234;
    #1 reset = 1'b0;
    tick(); tick();
    check_reset_outs("rst");
    idle_inputs();
    reset = 1'b1;
    tick();

    // host write then read at 0x10
    host_cen = 1'b0; host_wen = 1'b0; host_addr = 7'h10; host_d = 32'hA5A5A5A5;
    #1;
    check("a_mem_cen", 64'(mem_cen), 64'd0);
    check("a_mem_wen", 64'(mem_wen), 64'd0);
    check("a_mem_addr", 64'(mem_addr), 64'h10);
    check("a_mem_d", 64'(mem_d), 64'hA5A5A5A5);
    tick();
    host_wen = 1'b1;
    exp_q.push_back({1'b0, 32'hA5A5A5A5});
    tick();
    idle_inputs();
    check("a_access_cnt", 64'(access_cnt), 64'd2);
    check("a_qvalid_early", 64'(host_qvalid), 64'd0);
    tick();
    check("a_host_qvalid", 64'(host_qvalid), 64'd1);
    check("a_host_q", 64'(host_q), 64'hA5A5A5A5);
    check("a_core_qvalid", 64'(core_qvalid), 64'd0);
    tick();
    check("a_qvalid_pulse", 64'(host_qvalid), 64'd0);

    // host read in the same cycle host_sel drops
    host_sel = 1'b0; host_cen = 1'b0; host_wen = 1'b1; host_addr = 7'h10;
    exp_q.push_back({1'b0, 32'hA5A5A5A5});
    tick();
    idle_inputs();
    check("b_owner_drain1", 64'(owner), 64'd1);
    check("b_grant_drain1", 64'(core_grant), 64'd0);
    tick();
    check("b_owner_drain2", 64'(owner), 64'd1);
    check("b_host_qvalid_drain", 64'(host_qvalid), 64'd1);
    check("b_host_q_drain", 64'(host_q), 64'hA5A5A5A5);
    tick();
    check("b_owner_core", 64'(owner), 64'd2);
    check("b_core_grant", 64'(core_grant), 64'd1);
    check("b_cnt_clear", 64'(access_cnt), 64'd0);
    check("b_host_err", 64'(host_err), 64'd0);

    // core write then read at 0x11
    core_cen = 1'b0; core_wen = 1'b0; core_addr = 7'h11; core_d = 32'h3C3C0F0F;
    #1;
    check("c_mem_addr", 64'(mem_addr), 64'h11);
    check("c_mem_d", 64'(mem_d), 64'h3C3C0F0F);
    tick();
    core_wen = 1'b1;
    exp_q.push_back({1'b1, 32'h3C3C0F0F});
    tick();
    idle_inputs();
    check("c_access_cnt", 64'(access_cnt), 64'd2);
    tick();
    check("c_core_qvalid", 64'(core_qvalid), 64'd1);
    check("c_core_q", 64'(core_q), 64'h3C3C0F0F);
    check("c_host_qvalid", 64'(host_qvalid), 64'd0);
    tick();

    // illegal host write while core owns the SRAM
    core_addr = 7'h05;
    host_cen = 1'b0; host_wen = 1'b0; host_addr = 7'h10; host_d = 32'hDEADBEEF;
    #1;
    check("d_mem_cen", 64'(mem_cen), 64'd1);
    check("d_mem_wen", 64'(mem_wen), 64'd1);
    check("d_mem_addr", 64'(mem_addr), 64'h05);
    tick();
    idle_inputs();
    check("d_host_err", 64'(host_err), 64'd1);
    check("d_access_cnt", 64'(access_cnt), 64'd2);

    // back to host; 0x10 must still hold the original word
    host_sel = 1'b1;
    tick();
    check("e_owner_d2h", 64'(owner), 64'd3);
    tick(); tick();
    check("e_owner_host", 64'(owner), 64'd0);
    check("e_host_err_held", 64'(host_err), 64'd1);
    check("e_cnt_clear", 64'(access_cnt), 64'd0);
    host_cen = 1'b0; host_wen = 1'b1; host_addr = 7'h10;
    exp_q.push_back({1'b0, 32'hA5A5A5A5});
    tick();
    idle_inputs();

    // host_sel toggles inside the drain to core
    host_sel = 1'b0;
    tick();
    host_sel = 1'b1;
    check("f_owner_drain1", 64'(owner), 64'd1);
    tick();
    host_sel = 1'b0;
    check("f_owner_drain2", 64'(owner), 64'd1);
    tick();
    check("f_owner_core", 64'(owner), 64'd2);
    host_sel = 1'b1;
    tick();
    check("f_owner_d2h", 64'(owner), 64'd3);
    check("f_host_err_held", 64'(host_err), 64'd1);
    host_sel = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("g_owner_core", 64'(owner), 64'd2);

    // access counter saturation with 20 core writes
    for (int i = 0; i < 20; i++) begin
      core_cen = 1'b0; core_wen = 1'b0; core_addr = AW'(i + 32); core_d = DW'(i);
      tick();
      if (i == 13) check("g_cnt_14", 64'(access_cnt), 64'd14);
    end
    check("g_cnt_sat", 64'(access_cnt), 64'd15);
    host_sel = 1'b1;
    core_addr = 7'h07; core_d = 32'h77;
    tick();
    check("g_drain_mem_cen", 64'(mem_cen), 64'd1);
    check("g_drain_mem_wen", 64'(mem_wen), 64'd1);
    check("g_drain_mem_addr", 64'(mem_addr), 64'd0);
    check("g_drain_mem_d", 64'(mem_d), 64'd0);
    check("g_drain_cnt", 64'(access_cnt), 64'd15);
    tick(); tick();
    idle_inputs();
    check("g_owner_host", 64'(owner), 64'd0);
    check("g_cnt_host_clear", 64'(access_cnt), 64'd0);

    // reset with a core read in flight
    host_sel = 1'b0;
    tick(); tick(); tick();
    check("h_owner_core", 64'(owner), 64'd2);
    core_cen = 1'b0; core_wen = 1'b1; core_addr = 7'h20;
    tick();
    idle_inputs();
    reset = 1'b0;
    #1;
    check_reset_outs("h_rst");
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
